// File: rtl/dmx_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : dmx_receiver
//  Description : DMX512 receiver. Synchronizes the raw RS-485 line onto
//                CLK12, detects BREAK and MAB, deframes 8N2 slots and strobes
//                each slot (start code = index 0) with its index and byte.
//                Optional macro START_CODE_FILTER_EN suppresses data-slot
//                strobes for packets whose start code is non-zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmx_receiver #(
    parameter int CLKS_PER_BIT   = 48,
    parameter int BREAK_MIN_CLKS = 1056,
    parameter int MAB_MIN_CLKS   = 96,
    parameter int MAX_SLOTS      = 512
) (
    input  logic       CLK12,
    input  logic       RESET,
    input  logic       dmx_rx,
    output logic       slot_valid,
    output logic [9:0] slot_index,
    output logic [7:0] slot_data,
    output logic       packet_end,
    output logic [9:0] slot_total,
    output logic       frame_error
);

    localparam int c_LOW_W = $clog2(BREAK_MIN_CLKS + 1);
    localparam int c_MAB_W = $clog2(MAB_MIN_CLKS + 1);
    localparam int c_TMR_W = $clog2(CLKS_PER_BIT + 1);

    localparam logic [c_LOW_W-1:0] c_BREAK_CNT = c_LOW_W'(BREAK_MIN_CLKS);
    localparam logic [c_MAB_W-1:0] c_MAB_CNT   = c_MAB_W'(MAB_MIN_CLKS);
    localparam logic [c_TMR_W-1:0] c_HALF_LAST = c_TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TMR_W-1:0] c_BIT_LAST  = c_TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [9:0]         c_SLOT_MAX  = 10'(MAX_SLOTS);
    localparam logic [9:0]         c_SLOT_SAT  = 10'(MAX_SLOTS + 1);

    localparam logic [2:0] S_WAIT_BREAK = 3'd0;
    localparam logic [2:0] S_BREAK      = 3'd1;
    localparam logic [2:0] S_MAB        = 3'd2;
    localparam logic [2:0] S_MARK       = 3'd3;
    localparam logic [2:0] S_START      = 3'd4;
    localparam logic [2:0] S_DATA       = 3'd5;
    localparam logic [2:0] S_STOP       = 3'd6;

    logic               r_rx_meta;
    logic               r_rx_s;
    logic [c_LOW_W-1:0] r_low_cnt;
    logic [c_MAB_W-1:0] r_mab_cnt;
    logic [c_TMR_W-1:0] r_timer;
    logic [2:0]         r_state;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [9:0]         r_slot_cnt;
    logic               w_break;
    logic               w_tick;
    logic               w_slot_allow;

    // Two-flop synchronizer; idles high so reset never looks like a BREAK
    always_ff @(posedge CLK12 or posedge RESET) begin
        if (RESET) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= dmx_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Saturating count of consecutive low cycles, independent of FSM state
    always_ff @(posedge CLK12 or posedge RESET) begin
        if (RESET) begin
            r_low_cnt <= '0;
        end else if (r_rx_s) begin
            r_low_cnt <= '0;
        end else if (r_low_cnt != c_BREAK_CNT) begin
            r_low_cnt <= r_low_cnt + 1'b1;
        end
    end

    // Qualify with the live line level so the first high cycle after a
    // BREAK is already seen by S_BREAK rather than by the override
    assign w_break = !r_rx_s && (r_low_cnt == c_BREAK_CNT);
    assign w_tick  = (r_timer == c_BIT_LAST);

`ifdef START_CODE_FILTER_EN
    logic r_sc_bad;

    // Remember whether the current packet carries a non-zero start code
    always_ff @(posedge CLK12 or posedge RESET) begin
        if (RESET) begin
            r_sc_bad <= 1'b0;
        end else if (w_break) begin
            r_sc_bad <= 1'b0;
        end else if (r_state == S_STOP && w_tick && r_rx_s && r_slot_cnt == 10'd0) begin
            r_sc_bad <= (r_shift != 8'h00);
        end
    end

    assign w_slot_allow = (r_slot_cnt == 10'd0) || !r_sc_bad;
`else
    assign w_slot_allow = 1'b1;
`endif

    // Framing FSM; the BREAK override has priority over every state
    always_ff @(posedge CLK12 or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_WAIT_BREAK;
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_mab_cnt   <= '0;
            r_slot_cnt  <= '0;
            slot_valid  <= 1'b0;
            slot_index  <= '0;
            slot_data   <= '0;
            packet_end  <= 1'b0;
            slot_total  <= '0;
            frame_error <= 1'b0;
        end else begin
            slot_valid  <= 1'b0;
            packet_end  <= 1'b0;
            frame_error <= 1'b0;
            if (w_break) begin
                r_state <= S_BREAK;
                if (r_slot_cnt != 10'd0) begin
                    packet_end <= 1'b1;
                    slot_total <= r_slot_cnt;
                end
                r_slot_cnt <= '0;
            end else begin
                case (r_state)
                    S_WAIT_BREAK: r_state <= S_WAIT_BREAK;
                    S_BREAK: begin
                        if (r_rx_s) begin
                            r_state   <= S_MAB;
                            r_mab_cnt <= '0;
                        end
                    end
                    S_MAB: begin
                        if (r_rx_s) begin
                            if (r_mab_cnt != c_MAB_CNT) begin
                                r_mab_cnt <= r_mab_cnt + 1'b1;
                            end
                        end else if (r_mab_cnt == c_MAB_CNT) begin
                            r_state    <= S_START;
                            r_timer    <= '0;
                            r_slot_cnt <= '0;
                        end else begin
                            frame_error <= 1'b1;
                            r_state     <= S_WAIT_BREAK;
                        end
                    end
                    S_MARK: begin
                        if (!r_rx_s) begin
                            r_state <= S_START;
                            r_timer <= '0;
                        end
                    end
                    S_START: begin
                        if (r_timer == c_HALF_LAST) begin
                            r_timer   <= '0;
                            r_bit_idx <= '0;
                            if (r_rx_s) begin
                                // Glitch: return to wherever the low edge came from
                                r_state <= (r_slot_cnt == 10'd0) ? S_MAB : S_MARK;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (w_tick) begin
                            r_timer   <= '0;
                            r_shift   <= {r_rx_s, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                            if (r_bit_idx == 3'd7) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (w_tick) begin
                            r_timer <= '0;
                            if (r_rx_s) begin
                                if (r_slot_cnt <= c_SLOT_MAX && w_slot_allow) begin
                                    slot_valid <= 1'b1;
                                    slot_index <= r_slot_cnt;
                                    slot_data  <= r_shift;
                                end
                                if (r_slot_cnt != c_SLOT_SAT) begin
                                    r_slot_cnt <= r_slot_cnt + 1'b1;
                                end
                                r_state <= S_MARK;
                            end else begin
                                frame_error <= 1'b1;
                                r_state     <= S_WAIT_BREAK;
                            end
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    default: r_state <= S_WAIT_BREAK;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmx_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmx_receiver
//  Description : Scoreboard bench for dmx_receiver. Line-level stimulus tasks
//                push the events a DMX512 receiver must report; a monitor
//                pops and compares whenever the DUT strobes an output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmx_receiver;

    localparam int CPB      = 48;
    localparam int BRK_MIN  = 1056;
    localparam int MAB_MIN  = 96;
    localparam int MAXS     = 20;   // reduced so the long-packet case stays short

    localparam logic [1:0] K_SV = 2'd0;
    localparam logic [1:0] K_PE = 2'd1;
    localparam logic [1:0] K_FE = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [9:0] a;
        logic [7:0] b;
    } ev_t;

    logic       CLK12;
    logic       RESET;
    logic       dmx_rx;
    logic       slot_valid;
    logic [9:0] slot_index;
    logic [7:0] slot_data;
    logic       packet_end;
    logic [9:0] slot_total;
    logic       frame_error;

    int  checks;
    int  errors;
    ev_t q[$];

    // Reference receiver state, in DMX terms
    bit  m_synced;    // a valid MAB has been seen; slots are being accepted
    bit  m_broken;    // a BREAK has been seen, MAB not yet judged
    bit  m_sc_bad;    // start code of this packet was non-zero
    int  m_cnt;       // slots counted in this packet (saturating)

    dmx_receiver #(
        .CLKS_PER_BIT  (CPB),
        .BREAK_MIN_CLKS(BRK_MIN),
        .MAB_MIN_CLKS  (MAB_MIN),
        .MAX_SLOTS     (MAXS)
    ) dut (
        .CLK12      (CLK12),
        .RESET      (RESET),
        .dmx_rx     (dmx_rx),
        .slot_valid (slot_valid),
        .slot_index (slot_index),
        .slot_data  (slot_data),
        .packet_end (packet_end),
        .slot_total (slot_total),
        .frame_error(frame_error)
    );

    initial CLK12 = 1'b0;
    always #5 CLK12 = ~CLK12;

    function automatic ev_t mk(input logic [1:0] k, input int a, input int b);
        ev_t e;
        e.kind = k;
        e.a    = 10'(a);
        e.b    = 8'(b);
        return e;
    endfunction

    task automatic expect_ev(input logic [1:0] kind, input logic [9:0] a, input logic [7:0] b);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d a=%0d b=%02h required=none", kind, a, b);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.a != a || (kind == K_SV && e.b != b)) begin
                errors++;
                $display("FAIL event got kind=%0d a=%0d b=%02h required kind=%0d a=%0d b=%02h",
                         kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic hold(input logic v, input int n);
        dmx_rx = v;
        repeat (n) @(posedge CLK12);
    endtask

    // Line low for len cycles: a too-long low inside a packet is a framing
    // error; a low long enough is a BREAK which ends the current packet
    task automatic line_low(input int len);
        if (m_synced && len >= 10 * CPB) begin
            q.push_back(mk(K_FE, 0, 0));
            m_synced = 0;
        end
        if (len >= BRK_MIN + 8) begin
            if (m_cnt > 0) q.push_back(mk(K_PE, m_cnt, 0));
            m_cnt    = 0;
            m_broken = 1;
            m_synced = 0;
            m_sc_bad = 0;
        end
        hold(1'b0, len);
    endtask

    // Line high for len cycles; directly after a BREAK this is the MAB
    task automatic line_high(input int len);
        if (m_broken) begin
            if (len >= MAB_MIN + 8) m_synced = 1;
            else                    q.push_back(mk(K_FE, 0, 0));
            m_broken = 0;
        end
        hold(1'b1, len);
    endtask

    task automatic send_slot(input logic [7:0] b, input bit stop_ok);
        bit allow;
        if (m_synced) begin
            if (stop_ok) begin
                allow = (m_cnt <= MAXS);
`ifdef START_CODE_FILTER_EN
                if (m_cnt > 0 && m_sc_bad) allow = 0;
`endif
                if (allow) q.push_back(mk(K_SV, m_cnt, b));
                if (m_cnt == 0) m_sc_bad = (b != 8'h00);
                if (m_cnt <= MAXS) m_cnt++;
            end else begin
                q.push_back(mk(K_FE, 0, 0));
                m_synced = 0;
            end
        end
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_ok ? 1'b1 : 1'b0, CPB);
        hold(1'b1, CPB + int'($urandom_range(0, 20)));
    endtask

    initial begin
        logic [7:0] rb;
        int         n;
        checks   = 0;
        errors   = 0;
        m_synced = 0;
        m_broken = 0;
        m_sc_bad = 0;
        m_cnt    = 0;
        RESET    = 1'b1;
        dmx_rx   = 1'b1;

        fork
            forever begin
                @(negedge CLK12);
                if (!RESET) begin
                    if (slot_valid)  expect_ev(K_SV, slot_index, slot_data);
                    if (packet_end)  expect_ev(K_PE, slot_total, 8'h00);
                    if (frame_error) expect_ev(K_FE, 10'd0, 8'h00);
                end
            end
        join_none

        repeat (3) @(posedge CLK12);
        #1;
        check_val("rst_slot_valid",  int'(slot_valid),  0);
        check_val("rst_slot_index",  int'(slot_index),  0);
        check_val("rst_slot_data",   int'(slot_data),   0);
        check_val("rst_packet_end",  int'(packet_end),  0);
        check_val("rst_slot_total",  int'(slot_total),  0);
        check_val("rst_frame_error", int'(frame_error), 0);
        @(negedge CLK12);
        RESET = 1'b0;
        hold(1'b1, 50);

        // Basic packet
        line_low(1200);
        line_high(144);
        send_slot(8'h00, 1);
        send_slot(8'hFF, 1);
        send_slot(8'h05, 1);
        line_low(1200);
        line_high(144);

        // Bad first stop bit on slot 1; the rest of the packet is ignored
        send_slot(8'h00, 1);
        send_slot(8'h55, 0);
        send_slot(8'h11, 1);
        send_slot(8'h22, 1);

        // Low pulse shorter than a BREAK, then valid-looking slots
        line_low(960);
        line_high(144);
        send_slot(8'h00, 1);
        send_slot(8'h33, 1);

        // Glitch in the mark between slots
        line_low(1200);
        line_high(144);
        send_slot(8'h00, 1);
        send_slot(8'h9A, 1);
        hold(1'b0, 10);
        hold(1'b1, 100);
        send_slot(8'h6B, 1);

        // Non-zero start code
        line_low(1200);
        line_high(144);
        send_slot(8'hCC, 1);
        send_slot(8'h01, 1);
        send_slot(8'h02, 1);

        // Short MAB
        line_low(1200);
        line_high(40);
        send_slot(8'h00, 1);

        // Randomized packets
        for (int p = 0; p < 3; p++) begin
            line_low(int'($urandom_range(1100, 1300)));
            line_high(int'($urandom_range(120, 200)));
            n = int'($urandom_range(1, 5));
            for (int s = 0; s < n; s++) begin
                rb = 8'($urandom);
                if (s == 0 && $urandom_range(0, 1) == 0) rb = 8'h00;
                send_slot(rb, 1);
            end
        end

        // Packet longer than MAX_SLOTS data slots
        line_low(1200);
        line_high(144);
        for (int s = 0; s < MAXS + 8; s++) send_slot(8'(s), 1);

        // Reset in the middle of slot 3
        line_low(1200);
        line_high(144);
        send_slot(8'h00, 1);
        send_slot(8'hA5, 1);
        send_slot(8'h3C, 1);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        #2;
        RESET = 1'b1;
        #1;
        check_val("midrst_slot_valid", int'(slot_valid), 0);
        check_val("midrst_slot_index", int'(slot_index), 0);
        check_val("midrst_slot_data",  int'(slot_data),  0);
        check_val("midrst_slot_total", int'(slot_total), 0);
        m_synced = 0;
        m_broken = 0;
        m_sc_bad = 0;
        m_cnt    = 0;
        repeat (2) @(posedge CLK12);
        @(negedge CLK12);
        RESET = 1'b0;
        for (int i = 3; i < 8; i++) hold(i[0], CPB);
        hold(1'b1, 2 * CPB);
        send_slot(8'h77, 1);
        line_low(1200);
        line_high(144);
        send_slot(8'h00, 1);
        send_slot(8'h42, 1);
        line_low(1200);
        line_high(300);

        check_val("queue_empty_at_end", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
